// File: rtl/decade_cnt_arbiter.sv
// Round-robin arbiter sharing one mod-10 counter among NREQ requesters.
// Optional build macro DECADE_CNT_CLR_ON_GRANT_EN clears the counter at each legal grant.
module decade_cnt_arbiter #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] len,
    output logic [NREQ-1:0]       gnt,
    output logic                  busy,
    output logic                  cnt_en,
    output logic [3:0]            cnt,
    output logic [NREQ-1:0]       done,
    output logic                  err
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]       state;
    logic [IDX_W-1:0] ptr;
    logic [LEN_W-1:0] rem;

    logic             found;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic [NREQ-1:0]  win_onehot;
    logic [LEN_W-1:0] len_win;
    logic             illegal;
    logic             grant_now;
    logic             cnt_clr;
    int               idx;

    // Search upward from the requester after the last one granted, wrapping around.
    always_comb begin
        found      = 1'b0;
        win        = '0;
        cand       = '0;
        idx        = 0;
        len_win    = '0;
        win_onehot = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx  = (int'(ptr) + i) % NREQ;
            cand = IDX_W'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (IDX_W'(i) == win) begin
                len_win = len[i*LEN_W +: LEN_W];
            end
        end
        win_onehot[win] = 1'b1;
    end

    assign illegal   = (len_win == '0) || ({{(32-LEN_W){1'b0}}, len_win} > 32'd9);
    assign grant_now = (state == IDLE) && (|req);

`ifdef DECADE_CNT_CLR_ON_GRANT_EN
    assign cnt_clr = grant_now && !illegal;
`else
    assign cnt_clr = 1'b0;
`endif

    // Outputs are registered from the state being entered, so each one lines up with its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= IDX_W'(NREQ - 1);
            rem    <= '0;
            gnt    <= '0;
            busy   <= 1'b0;
            cnt_en <= 1'b0;
            done   <= '0;
            err    <= 1'b0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_now) begin
                        state <= GRANT;
                        busy  <= 1'b1;
                        gnt   <= win_onehot;
                        ptr   <= win;
                        rem   <= len_win;
                        err   <= illegal;
                    end
                end
                GRANT: begin
                    // err is high exactly when the latched length was illegal.
                    if (err) begin
                        state <= DONE;
                        done  <= gnt;
                    end else begin
                        state  <= RUN;
                        cnt_en <= 1'b1;
                    end
                end
                RUN: begin
                    rem <= rem - LEN_W'(1);
                    if (rem == LEN_W'(1)) begin
                        state  <= DONE;
                        cnt_en <= 1'b0;
                        done   <= gnt;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (cnt_clr) begin
            cnt <= 4'd0;
        end else if (cnt_en) begin
            cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
        end
    end

endmodule

// File: doc/decade_cnt_arbiter.md
# decade_cnt_arbiter

Round-robin arbiter and sequencer that shares one mod-10 (0–9) counter among `NREQ` requesters. Each requester asks for a burst of 1–9 count steps. The block grants the counter to one requester at a time, drives the count enable for exactly the requested number of cycles, and signals completion. It sits between the requesting control blocks and the shared decade counter datapath, which is instantiated inside this block.

## Interface
- `NREQ`, default 4: number of requesters, 2–8.
- `LEN_W`, default 4: width of each requester's burst-length field.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `req`  in  `NREQ`: request lines, one per requester; level-sensitive.
- `len`  in  `NREQ*LEN_W`: packed burst lengths; requester i uses `len[i*LEN_W +: LEN_W]`.
- `gnt`  out  `NREQ`: one-hot grant; all zero when idle.
- `busy`  out  1: high in any state other than IDLE.
- `cnt_en`  out  1: enable of the shared counter; high only in RUN.
- `cnt`  out  4: shared counter value, 0–9.
- `done`  out  `NREQ`: one-cycle completion pulse to the granted requester.
- `err`  out  1: one-cycle pulse when a granted length is illegal.

## Operation
- Reset values: state IDLE, `gnt`=0, `busy`=0, `cnt_en`=0, `cnt`=0, `done`=0, `err`=0. The round-robin pointer is set so requester 0 has highest priority first.
- States:
  - IDLE: if `req` is nonzero, go to GRANT; otherwise stay.
  - GRANT: go to RUN, or to DONE if the length is illegal.
  - RUN: go to DONE when the remaining count reaches 0.
  - DONE: go to IDLE.
- Arbitration happens in IDLE. The winner is the first set `req` bit searching upward, with wrap, from the index after the last granted requester. The pointer updates on entry to GRANT.
- In GRANT, `gnt` is set to the one-hot winner and held through DONE. The winner's length is latched into a remaining-count register.
- Legal lengths are 1–9. A length of 0 or greater than 9 is illegal: `err` pulses in GRANT, RUN is skipped, and `done` still pulses for that requester in DONE. The counter is untouched.
- In RUN, `cnt_en`=1 every cycle. `cnt` increments by 1 and wraps from 9 to 0. The remaining count decrements by 1 each cycle.
- In DONE, `done[winner]`=1 for one cycle. `gnt` clears on exit to IDLE.
- `req` and `len` changes after GRANT are ignored; the latched burst always completes. Requesters deassert `req` on `done`. A `req` still high in IDLE is treated as a new request.
- `cnt` is never cleared between bursts, because the counter is a shared resource; the only exception is the configuration feature below.
- `rst` asserted in any state takes effect at the next edge: all outputs return to their reset values and any burst in progress is dropped without a `done` pulse.

## Timing
- `req` seen in IDLE at edge t: `gnt` high from t+1 (GRANT).
- RUN occupies cycles t+2 through t+1+L, with `cnt` updating at each of those edges.
- `done` pulses at cycle t+2+L. The block is back in IDLE at t+3+L.
- Earliest next grant is t+4+L, so back-to-back bursts are separated by 3 overhead cycles.
- Illegal length: GRANT with `err` at t+1, `done` at t+2.
- All outputs are registered. No combinational path from inputs to outputs.

## Configuration
- `DECADE_CNT_CLR_ON_GRANT_EN`
  - Defined: `cnt` is cleared to 0 in the GRANT cycle, so every burst starts from 0 and ends with `cnt`=L.
  - Undefined: `cnt` carries over from the previous burst, and the burst ends at (previous `cnt` + L) mod 10.
  - An illegal-length grant does not clear `cnt` in either build.

## Test plan
- Reset, then `req`=0001 with len0=5: `gnt`=0001, 5 cycles of `cnt_en`, `cnt` steps 0→5, `done`=0001 one cycle, `busy` low after.
- Wrap, macro undefined: len0=7, then len0=6 → `cnt` goes 0→7, then 7→9→0→3; final `cnt`=3.
- Fairness: `req`=1111 held, all lengths 1 → grant order 0,1,2,3,0, and each grant has exactly one `cnt_en` cycle.
- Illegal length: len2=0, then len2=12 → each gives an `err` pulse, `done`=0100, no `cnt_en`, `cnt` unchanged.
- Reset mid-RUN: `rst` high on the 3rd RUN cycle of a len=9 burst → next cycle `cnt`=0, `gnt`=0, no `done`.
- Macro defined: `cnt`=4 before GRANT, len=3 → `cnt` is 0 in GRANT and ends at 3.
